ids_bus_arbiter: RTL

IDS_BUS_ARBITER -- requirements
Module: ids_bus_arbiter

---
 rtl/ids_bus_arbiter_pkg.sv | 17 +
 rtl/ids_bus_arbiter_if.sv | 31 +++
 rtl/ids_bus_arbiter_rr_pick.sv | 35 +++
 rtl/ids_bus_arbiter.sv | 103 ++++++++++
 4 files changed

// File: rtl/ids_bus_arbiter_pkg.sv
// rtl/ids_bus_arbiter_pkg.sv - shared bus types and master-index constants for the IDS arbiter
package ids_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GRANT    = 2'd1,
      HANDOVER = 2'd2
   } arb_state_t;

   localparam int MST_SPI  = 0;
   localparam int MST_DMEM = 1;
   localparam int MST_DMA  = 2;

   // Owner index is a fixed 2-bit field on the bus, so at most four requesters.
   localparam int OWNER_W = 2;

endpackage

// File: rtl/ids_bus_arbiter_if.sv
// rtl/ids_bus_arbiter_if.sv - request/grant bundle between IDS bus masters and the arbiter
interface ids_bus_arbiter_if
   import ids_bus_arbiter_pkg::*;
#(
   parameter int N_REQ = 3
);
   logic [N_REQ-1:0]   i_req;
   logic               i_spi_prio;
   logic [N_REQ-1:0]   o_gnt;
   logic [OWNER_W-1:0] o_owner;
   logic               o_busy;
   logic               o_timeout;

   modport master (
      output i_req,
      output i_spi_prio,
      input  o_gnt,
      input  o_owner,
      input  o_busy,
      input  o_timeout
   );

   modport slave (
      input  i_req,
      input  i_spi_prio,
      output o_gnt,
      output o_owner,
      output o_busy,
      output o_timeout
   );
endinterface

// File: rtl/ids_bus_arbiter_rr_pick.sv
// rtl/ids_bus_arbiter_rr_pick.sv - combinational round-robin picker, search starts after last_owner
module rr_pick #(
   parameter int N     = 3,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last_owner,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx
);
   int               cand;
   logic [IDX_W-1:0] c;
   logic             found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      c     = '0;
      // i == N wraps back to last_owner itself, so a lone requester still wins.
      for (int i = 1; i <= N; i++) begin
         cand = int'(last_owner) + i;
         if (cand >= N) begin
            cand = cand - N;
         end
         c = IDX_W'(cand);
         if (!found && req[c]) begin
            found  = 1'b1;
            gnt[c] = 1'b1;
            idx    = c;
         end
      end
   end
endmodule

// File: rtl/ids_bus_arbiter.sv
// rtl/ids_bus_arbiter.sv - non-preemptive bus arbiter with optional SPI priority and hold timeout
module ids_bus_arbiter
   import ids_bus_arbiter_pkg::*;
#(
   parameter int N_REQ    = 3,
   parameter int MAX_HOLD = 256
) (
   input logic              i_clk,
   input logic              i_rst_n,
   ids_bus_arbiter_if.slave bus
);
   localparam int                 CNT_W      = $clog2(MAX_HOLD) + 1;
   localparam logic [CNT_W-1:0]   HOLD_LIMIT = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0]   HOLD_PRE   = CNT_W'(MAX_HOLD - 1);
   localparam logic [OWNER_W-1:0] LAST_RST   = OWNER_W'(N_REQ - 1);

   arb_state_t         state_q, state_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [OWNER_W-1:0] owner_q, owner_d;
   logic [OWNER_W-1:0] last_q, last_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               timeout_q, timeout_d;

   logic [N_REQ-1:0]   rr_gnt;
   logic [OWNER_W-1:0] rr_idx;
   logic               prio_win;
   logic               others_waiting;

   rr_pick #(
      .N     (N_REQ),
      .IDX_W (OWNER_W)
   ) u_rr_pick (
      .req        (bus.i_req),
      .last_owner (last_q),
      .gnt        (rr_gnt),
      .idx        (rr_idx)
   );

   assign prio_win       = bus.i_spi_prio & bus.i_req[MST_SPI];
   assign others_waiting = |(bus.i_req & ~gnt_q);

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      owner_d   = owner_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE, HANDOVER: begin
            // Arbitration point: the only place i_spi_prio is looked at.
            if (|bus.i_req) begin
               state_d = GRANT;
               gnt_d   = prio_win ? N_REQ'(1) : rr_gnt;
               owner_d = prio_win ? OWNER_W'(MST_SPI) : rr_idx;
               last_d  = prio_win ? OWNER_W'(MST_SPI) : rr_idx;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
               gnt_d   = '0;
            end
         end
         GRANT: begin
            if (others_waiting && (cnt_q < HOLD_LIMIT)) begin
               cnt_d     = cnt_q + 1'b1;
               timeout_d = (cnt_q == HOLD_PRE);
            end
            if (!bus.i_req[owner_q]) begin
               state_d = HANDOVER;
               gnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         owner_q   <= '0;
         last_q    <= LAST_RST;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.o_gnt     = gnt_q;
   assign bus.o_owner   = owner_q;
   assign bus.o_busy    = |gnt_q;
   assign bus.o_timeout = timeout_q;

endmodule
